// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: initial vector, round constants, FSM states and
// the round-dependent boolean function.
package sha1_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } sha1_state_e;

  localparam logic [31:0] IV_H0 = 32'h67452301;
  localparam logic [31:0] IV_H1 = 32'hEFCDAB89;
  localparam logic [31:0] IV_H2 = 32'h98BADCFE;
  localparam logic [31:0] IV_H3 = 32'h10325476;
  localparam logic [31:0] IV_H4 = 32'hC3D2E1F0;
  localparam logic [159:0] SHA1_IV = {IV_H0, IV_H1, IV_H2, IV_H3, IV_H4};

  localparam logic [31:0] K_0_19  = 32'h5A827999;
  localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
  localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
  localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

  function automatic logic [31:0] sha1_k(input logic [6:0] t);
    if (t < 7'd20)      return K_0_19;
    else if (t < 7'd40) return K_20_39;
    else if (t < 7'd60) return K_40_59;
    else                return K_60_79;
  endfunction

  // Ch for rounds 0-19, Maj for 40-59, parity otherwise.
  function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round; working variables packed as {a,b,c,d,e}.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [6:0]   t_i,
  input  logic [31:0]  w_i,
  input  logic [159:0] st_i,
  output logic [159:0] st_o
);

  logic [31:0] a, b, c, d, e;
  logic [31:0] temp;

  assign {a, b, c, d, e} = st_i;
  assign temp = {a[26:0], a[31:27]} + sha1_f(t_i, b, c, d) + e + sha1_k(t_i) + w_i;
  assign st_o = {temp, a, {b[1:0], b[31:2]}, c, d};

endmodule

// File: rtl/sha1_core_param.sv
// SHA-1 compression core with configurable beat width and rounds per clock;
// chains digests across blocks through an internal CV register.
module sha1_core_param
  import sha1_pkg::*;
#(
  parameter int DIN_W       = 32,
  parameter int RND_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic [DIN_W-1:0] din,
  input  logic             use_prec_cv,
  output logic             busy,
  output logic             dout_vld,
  output logic [159:0]     dout
);

  localparam int WPB     = DIN_W / 32;
  localparam int BEATS   = 512 / DIN_W;
  localparam int RND_CYC = 80 / RND_PER_CYC;

  generate
    if (!((DIN_W == 32 || DIN_W == 64) &&
          (RND_PER_CYC == 1 || RND_PER_CYC == 2 || RND_PER_CYC == 4 || RND_PER_CYC == 5)))
    begin : g_bad_param
      $error("sha1_core_param: illegal DIN_W or RND_PER_CYC");
    end
  endgenerate

  sha1_state_e  state_q, state_d;
  logic [3:0]   beat_cnt_q, beat_cnt_d;
  logic [6:0]   rnd_cnt_q, rnd_cnt_d;
  logic         rdy_en_q;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [31:0]  ext [16+RND_PER_CYC];
  logic [159:0] wv_q, wv_d;
  logic [159:0] cv_q, cv_d;
  logic [159:0] dout_q, dout_d;
  logic [159:0] chain [RND_PER_CYC+1];
  logic [159:0] cv_sum;
  logic         accept;

  // rdy_en_q keeps din_rdy low until the first edge after reset release.
  assign din_rdy  = rdy_en_q && (state_q == S_IDLE || state_q == S_LOAD);
  assign accept   = din_vld && din_rdy;
  assign busy     = (state_q != S_IDLE);
  assign dout_vld = (state_q == S_DONE);
  assign dout     = dout_q;

  // ext[0..15] is the live window, ext[16..] the words expanded this cycle.
  always_comb begin : sched_expand
    logic [31:0] x;
    x = '0;
    for (int j = 0; j < 16; j++) ext[j] = w_q[j];
    for (int m = 0; m < RND_PER_CYC; m++) begin
      x = ext[13+m] ^ ext[8+m] ^ ext[2+m] ^ ext[m];
      ext[16+m] = {x[30:0], x[31]};
    end
  end

  assign chain[0] = wv_q;

  for (genvar i = 0; i < RND_PER_CYC; i++) begin : g_rnd
    logic [6:0] t_idx;
    assign t_idx = 7'(int'(rnd_cnt_q) * RND_PER_CYC + i);
    sha1_round u_round (
      .t_i  (t_idx),
      .w_i  (ext[i]),
      .st_i (chain[i]),
      .st_o (chain[i+1])
    );
  end

  always_comb begin
    cv_sum = '0;
    for (int k = 0; k < 5; k++)
      cv_sum[32*k +: 32] = cv_q[32*k +: 32] + chain[RND_PER_CYC][32*k +: 32];
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rnd_cnt_d  = rnd_cnt_q;
    w_d        = w_q;
    wv_d       = wv_q;
    cv_d       = cv_q;
    dout_d     = dout_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          for (int k = 0; k < WPB; k++)
            w_d[4'(int'(beat_cnt_q) * WPB + k)] = din[DIN_W-1-32*k -: 32];
          // The chaining value is chosen once, with the first beat of a block.
          if (state_q == S_IDLE) begin
            wv_d = use_prec_cv ? cv_q : SHA1_IV;
            cv_d = wv_d;
          end
          if (beat_cnt_q == 4'(BEATS - 1)) begin
            beat_cnt_d = '0;
            rnd_cnt_d  = '0;
            state_d    = S_ROUND;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            state_d    = S_LOAD;
          end
        end
      end
      S_ROUND: begin
        wv_d = chain[RND_PER_CYC];
        for (int j = 0; j < 16; j++) w_d[j] = ext[j+RND_PER_CYC];
        rnd_cnt_d = rnd_cnt_q + 7'd1;
        if (rnd_cnt_q == 7'(RND_CYC - 1)) begin
          rnd_cnt_d = '0;
          cv_d      = cv_sum;
          dout_d    = cv_sum;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      rnd_cnt_q  <= '0;
      rdy_en_q   <= 1'b0;
      for (int j = 0; j < 16; j++) w_q[j] <= '0;
      wv_q       <= '0;
      cv_q       <= SHA1_IV;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rnd_cnt_q  <= rnd_cnt_d;
      rdy_en_q   <= 1'b1;
      w_q        <= w_d;
      wv_q       <= wv_d;
      cv_q       <= cv_d;
      dout_q     <= dout_d;
    end
  end

endmodule

// File: tb/tb_sha1_core_param.sv
// Directed bench for sha1_core_param with a digest scoreboard and an
// independent FIPS-style reference compression function.
module tb_sha1_core_param;

  parameter int DIN_W       = 32;
  parameter int RND_PER_CYC = 1;

  localparam int BEATS   = 512 / DIN_W;
  localparam int RND_CYC = 80 / RND_PER_CYC;

  localparam logic [159:0] IV_DIG    = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] ABC_DIG   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] EMPTY_DIG = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] TWO_DIG   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};

  logic             clk;
  logic             rst_n;
  logic             din_vld;
  logic             din_rdy;
  logic [DIN_W-1:0] din;
  logic             use_prec_cv;
  logic             busy;
  logic             dout_vld;
  logic [159:0]     dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int vld_pulses = 0;
  logic [159:0] exp_q[$];

  sha1_core_param #(
    .DIN_W       (DIN_W),
    .RND_PER_CYC (RND_PER_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_vld     (din_vld),
    .din_rdy     (din_rdy),
    .din         (din),
    .use_prec_cv (use_prec_cv),
    .busy        (busy),
    .dout_vld    (dout_vld),
    .dout        (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (dout_vld === 1'b1) vld_pulses++;

  function automatic logic [159:0] ref_compress(input logic [159:0] cv, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp, x;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {x[30:0], x[31]};
    end
    {a, b, c, d, e} = cv;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {cv[159:128] + a, cv[127:96] + b, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Feeds one block beat by beat; optional random gaps, optional din_vld held high afterwards.
  task automatic applyStimulus(input logic [511:0] blk, input logic prec, input int gap_max,
                               input logic hold, input logic [159:0] expected, input logic push);
    int g;
    int n;
    if (push) exp_q.push_back(expected);
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        din_vld = 1'b0;
        repeat (g) @(negedge clk);
      end
      din_vld     = 1'b1;
      din         = blk[511-DIN_W*k -: DIN_W];
      use_prec_cv = prec;
      n = 0;
      while (din_rdy !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (din_rdy !== 1'b1) checkOutput("beat_accept_timeout", {159'h0, din_rdy}, 160'h1);
      @(posedge clk);
    end
    @(negedge clk);
    acc_cyc = cyc;
    if (hold) begin
      din         = ~din;
      use_prec_cv = ~prec;
    end else begin
      din_vld = 1'b0;
    end
  endtask

  task automatic waitResult(input string tag);
    int n;
    logic rdy_hi;
    logic [159:0] expected;
    n = 0;
    rdy_hi = 1'b0;
    while (dout_vld !== 1'b1 && n < 300) begin
      rdy_hi = rdy_hi | (din_rdy !== 1'b0);
      @(negedge clk);
      n++;
    end
    expected = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (dout_vld !== 1'b1) begin
      checkOutput({tag, "_vld_timeout"}, {159'h0, dout_vld}, 160'h1);
    end else begin
      checkOutput({tag, "_digest"}, dout, expected);
      checkOutput({tag, "_latency"}, 160'(cyc - acc_cyc), 160'(RND_CYC));
      checkOutput({tag, "_rdy_round"}, {159'h0, rdy_hi}, 160'h0);
      checkOutput({tag, "_rdy_done"}, {159'h0, din_rdy}, 160'h0);
      din_vld = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_vld_pulse"}, {159'h0, dout_vld}, 160'h0);
      checkOutput({tag, "_idle"}, {159'h0, busy}, 160'h0);
      checkOutput({tag, "_dout_hold"}, dout, expected);
    end
  endtask

  initial begin
    logic [511:0] blk;
    logic [159:0] model_cv;
    logic [159:0] b1_dig;
    int p0;

    rst_n       = 1'b1;
    din_vld     = 1'b0;
    din         = '0;
    use_prec_cv = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {159'h0, busy}, 160'h0);
    checkOutput("rst_rdy", {159'h0, din_rdy}, 160'h0);
    checkOutput("rst_vld", {159'h0, dout_vld}, 160'h0);
    checkOutput("rst_dout", dout, 160'h0);
    rst_n = 1'b1;
    #1 checkOutput("rdy_before_edge", {159'h0, din_rdy}, 160'h0);
    @(negedge clk);
    checkOutput("rdy_after_edge", {159'h0, din_rdy}, 160'h1);

    $display("[TB] abc, empty and two-block messages");
    applyStimulus(ABC_BLK, 1'b0, 0, 1'b0, ABC_DIG, 1'b1);
    waitResult("abc");
    applyStimulus(EMPTY_BLK, 1'b0, 0, 1'b0, EMPTY_DIG, 1'b1);
    waitResult("empty");
    b1_dig = ref_compress(IV_DIG, TWO_B1);
    applyStimulus(TWO_B1, 1'b0, 0, 1'b0, b1_dig, 1'b1);
    waitResult("two_b1");
    applyStimulus(TWO_B2, 1'b1, 0, 1'b0, TWO_DIG, 1'b1);
    waitResult("two_b2");

    $display("[TB] gaps and held din_vld");
    applyStimulus(ABC_BLK, 1'b0, 3, 1'b0, ABC_DIG, 1'b1);
    waitResult("abc_gaps");
    applyStimulus(ABC_BLK, 1'b0, 0, 1'b1, ABC_DIG, 1'b1);
    waitResult("abc_hold");
    repeat (5) @(negedge clk);
    checkOutput("dout_hold_long", dout, ABC_DIG);

    $display("[TB] reset mid-round");
    applyStimulus(EMPTY_BLK, 1'b0, 0, 1'b0, EMPTY_DIG, 1'b0);
    repeat (RND_CYC / 2) @(negedge clk);
    p0 = vld_pulses;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {159'h0, busy}, 160'h0);
    checkOutput("midrst_rdy", {159'h0, din_rdy}, 160'h0);
    checkOutput("midrst_vld", {159'h0, dout_vld}, 160'h0);
    checkOutput("midrst_dout", dout, 160'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (RND_CYC + 10) @(negedge clk);
    checkOutput("midrst_no_vld", 160'(vld_pulses - p0), 160'h0);
    applyStimulus(ABC_BLK, 1'b1, 0, 1'b0, ABC_DIG, 1'b1);
    waitResult("abc_prec_after_rst");

    $display("[TB] random chained blocks");
    model_cv = IV_DIG;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom;
      model_cv = ref_compress((b == 0) ? IV_DIG : model_cv, blk);
      applyStimulus(blk, (b != 0), 2, 1'b0, model_cv, 1'b1);
      waitResult("chain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
